// File: rtl/bsg_fifo_multi_tracker_pkg.sv
// Shared constants and types for the multi-port FIFO occupancy tracker.
//   els_dflt_lp     : default number of buffer slots (power of two)
//   max_add_dflt_lp : default maximum enqueues/dequeues per cycle
//   *_width_lp      : widths derived from the defaults above
//   cnt_t           : request/grant count type at the default width
package bsg_fifo_multi_tracker_pkg;

    localparam int els_dflt_lp     = 64;
    localparam int max_add_dflt_lp = 5;

    localparam int ptr_width_lp = $clog2(els_dflt_lp);
    localparam int cnt_width_lp = $clog2(max_add_dflt_lp + 1);
    localparam int occ_width_lp = $clog2(els_dflt_lp + 1);

    typedef logic [cnt_width_lp-1:0] cnt_t;

endpackage

// File: rtl/bsg_fifo_multi_ptr_ar.sv
// Modular slot pointer that advances by a variable amount each cycle.
//   clk       : rising-edge clock
//   reset_n_i : synchronous active-low reset, clears the pointer to 0
//   add_i     : number of slots to advance this cycle
//   ptr_o     : current (registered) pointer
//   ptr_n_o   : pointer value after this cycle's add (combinational)
module bsg_fifo_multi_ptr_ar
    import bsg_fifo_multi_tracker_pkg::*;
#(
    parameter int slots_p   = els_dflt_lp,
    parameter int max_add_p = max_add_dflt_lp,
    localparam int ptr_w_lp = $clog2(slots_p),
    localparam int add_w_lp = $clog2(max_add_p + 1)
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic [add_w_lp-1:0] add_i,
    output logic [ptr_w_lp-1:0] ptr_o,
    output logic [ptr_w_lp-1:0] ptr_n_o
);

    logic [ptr_w_lp-1:0] ptr_reg;
    logic [ptr_w_lp:0]   sum_next;

    // One extra bit of headroom, then truncate: slots_p is a power of two,
    // so dropping the carry is exactly the modulo wrap.
    always_comb begin
        sum_next = {1'b0, ptr_reg} + (ptr_w_lp + 1)'(add_i);
        ptr_n_o  = sum_next[ptr_w_lp-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_n_o;
        end
    end

    assign ptr_o = ptr_reg;

endmodule

// File: rtl/bsg_fifo_multi_tracker.sv
// Occupancy and credit tracker for a circular buffer with up to max_add_p
// enqueues and dequeues per cycle.
//   clk       : rising-edge clock
//   reset_n_i : synchronous active-low reset
//   enq_req_i : entries the producer wants to write this cycle
//   enq_ack_o : entries accepted this cycle (combinational)
//   deq_req_i : entries the consumer wants to remove this cycle
//   deq_ack_o : entries removed this cycle (combinational)
//   wptr_o / wptr_n_o : current / next write slot
//   rptr_o / rptr_n_o : current / next read slot
//   occ_o, free_o     : entries held and free slots
//   full_o, empty_o   : occupancy flags
//   err_o             : sticky flag, set by any request above max_add_p
module bsg_fifo_multi_tracker
    import bsg_fifo_multi_tracker_pkg::*;
#(
    parameter int els_p     = els_dflt_lp,
    parameter int max_add_p = max_add_dflt_lp,
    localparam int ptr_w_lp = $clog2(els_p),
    localparam int cnt_w_lp = $clog2(max_add_p + 1),
    localparam int occ_w_lp = $clog2(els_p + 1)
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic [cnt_w_lp-1:0] enq_req_i,
    output logic [cnt_w_lp-1:0] enq_ack_o,
    input  logic [cnt_w_lp-1:0] deq_req_i,
    output logic [cnt_w_lp-1:0] deq_ack_o,
    output logic [ptr_w_lp-1:0] wptr_o,
    output logic [ptr_w_lp-1:0] wptr_n_o,
    output logic [ptr_w_lp-1:0] rptr_o,
    output logic [ptr_w_lp-1:0] rptr_n_o,
    output logic [occ_w_lp-1:0] occ_o,
    output logic [occ_w_lp-1:0] free_o,
    output logic                full_o,
    output logic                empty_o,
    output logic                err_o
);

    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_add_p);
    localparam logic [occ_w_lp-1:0] els_occ_lp = occ_w_lp'(els_p);

    logic [occ_w_lp-1:0] occ_reg, occ_next;
    logic                err_reg, err_next;
    logic [cnt_w_lp-1:0] enq_eff, deq_eff;
    logic                enq_bad, deq_bad;

    // Grants depend only on registered occupancy: space freed or entries
    // written in the same cycle are never bypassed into this cycle's grant.
    always_comb begin
        enq_bad = (enq_req_i > max_cnt_lp);
        deq_bad = (deq_req_i > max_cnt_lp);
        enq_eff = enq_bad ? max_cnt_lp : enq_req_i;
        deq_eff = deq_bad ? max_cnt_lp : deq_req_i;

        free_o = els_occ_lp - occ_reg;

        // When the clamp wins, free/occ is below max_add_p, so the
        // narrowing cast cannot lose bits.
        enq_ack_o = enq_eff;
        if (occ_w_lp'(enq_eff) > free_o) begin
            enq_ack_o = cnt_w_lp'(free_o);
        end
        deq_ack_o = deq_eff;
        if (occ_w_lp'(deq_eff) > occ_reg) begin
            deq_ack_o = cnt_w_lp'(occ_reg);
        end

        occ_next = occ_reg + occ_w_lp'(enq_ack_o) - occ_w_lp'(deq_ack_o);
        err_next = err_reg | enq_bad | deq_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            occ_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            occ_reg <= occ_next;
            err_reg <= err_next;
        end
    end

    bsg_fifo_multi_ptr_ar #(
        .slots_p   (els_p),
        .max_add_p (max_add_p)
    ) wptr_ar (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .add_i     (enq_ack_o),
        .ptr_o     (wptr_o),
        .ptr_n_o   (wptr_n_o)
    );

    bsg_fifo_multi_ptr_ar #(
        .slots_p   (els_p),
        .max_add_p (max_add_p)
    ) rptr_ar (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .add_i     (deq_ack_o),
        .ptr_o     (rptr_o),
        .ptr_n_o   (rptr_n_o)
    );

    assign occ_o   = occ_reg;
    assign full_o  = (occ_reg == els_occ_lp);
    assign empty_o = (occ_reg == '0);
    assign err_o   = err_reg;

endmodule

// File: tb/tb_bsg_fifo_multi_tracker.sv
// Directed testbench for bsg_fifo_multi_tracker with hand-computed values.
module tb_bsg_fifo_multi_tracker;

    logic       clk;
    logic       reset_n_i;
    logic [2:0] enq_req_i, enq_ack_o, deq_req_i, deq_ack_o;
    logic [5:0] wptr_o, wptr_n_o, rptr_o, rptr_n_o;
    logic [6:0] occ_o, free_o;
    logic       full_o, empty_o, err_o;

    int checks_total  = 0;
    int checks_passed = 0;

    bsg_fifo_multi_tracker dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .enq_req_i (enq_req_i),
        .enq_ack_o (enq_ack_o),
        .deq_req_i (deq_req_i),
        .deq_ack_o (deq_ack_o),
        .wptr_o    (wptr_o),
        .wptr_n_o  (wptr_n_o),
        .rptr_o    (rptr_o),
        .rptr_n_o  (rptr_n_o),
        .occ_o     (occ_o),
        .free_o    (free_o),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            checks_passed++;
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Apply requests, check the combinational grants mid-cycle, then
    // advance past the next rising edge.
    task automatic step(input int enq, input int deq, input int exp_enq, input int exp_deq,
                        input string tag);
        enq_req_i = 3'(enq);
        deq_req_i = 3'(deq);
        @(negedge clk);
        check({tag, ".enq_ack"}, enq_ack_o, exp_enq);
        check({tag, ".deq_ack"}, deq_ack_o, exp_deq);
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle with no checks (used for bulk positioning).
    task automatic tick(input int enq, input int deq);
        enq_req_i = 3'(enq);
        deq_req_i = 3'(deq);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        tick(5, 0);
        tick(5, 0);
        reset_n_i = 1'b1;
        enq_req_i = '0;
        deq_req_i = '0;
    endtask

    initial begin
        reset_n_i = 1'b0;
        enq_req_i = '0;
        deq_req_i = '0;

        // Reset with an active enqueue request held throughout
        do_reset();
        check("rst.wptr",  wptr_o,  0);
        check("rst.rptr",  rptr_o,  0);
        check("rst.occ",   occ_o,   0);
        check("rst.empty", empty_o, 1);
        check("rst.full",  full_o,  0);
        check("rst.free",  free_o,  64);
        check("rst.err",   err_o,   0);

        // Fill: 12 grants of 5, then 4 to reach 64
        for (int i = 0; i < 13; i++) begin
            step(5, 0, (i < 12) ? 5 : 4, 0, $sformatf("fill%0d", i + 1));
        end
        check("fill.occ",  occ_o,  64);
        check("fill.full", full_o, 1);
        check("fill.wptr", wptr_o, 0);
        check("fill.free", free_o, 0);
        step(5, 0, 0, 0, "fill14");
        check("fill14.occ", occ_o, 64);

        // Reposition to occ=64, rptr=10
        step(0, 5, 0, 5, "drain_a");
        step(0, 5, 0, 5, "drain_b");
        check("drain.rptr", rptr_o, 10);
        check("drain.occ",  occ_o,  54);
        step(5, 0, 5, 0, "refill_a");
        step(5, 0, 5, 0, "refill_b");
        check("refill.full", full_o, 1);

        // Simultaneous enq+deq at full: only the dequeue happens
        step(5, 5, 0, 5, "fullsim");
        check("fullsim.occ",  occ_o,  59);
        check("fullsim.rptr", rptr_o, 15);
        check("fullsim.wptr", wptr_o, 10);
        check("fullsim.full", full_o, 0);

        // Simultaneous enq+deq at empty: only the enqueue happens
        do_reset();
        step(2, 3, 2, 0, "emptysim");
        check("emptysim.occ",  occ_o,  2);
        check("emptysim.rptr", rptr_o, 0);
        check("emptysim.wptr", wptr_o, 2);

        // Bring both pointers to 62 with occ=0
        step(0, 2, 0, 2, "drain2");
        for (int i = 0; i < 12; i++) begin
            tick(5, 0);
            tick(0, 5);
        end
        check("pre_wrap.wptr", wptr_o, 62);
        check("pre_wrap.rptr", rptr_o, 62);
        check("pre_wrap.occ",  occ_o,  0);

        // Pointer wrap on enqueue then dequeue
        enq_req_i = 3'd5;
        deq_req_i = 3'd0;
        @(negedge clk);
        check("wrap.wptr_n", wptr_n_o, 3);
        @(posedge clk);
        #1;
        check("wrap.wptr", wptr_o, 3);
        check("wrap.occ",  occ_o,  5);
        enq_req_i = 3'd0;
        deq_req_i = 3'd5;
        @(negedge clk);
        check("wrap.rptr_n", rptr_n_o, 3);
        @(posedge clk);
        #1;
        check("wrap.rptr",  rptr_o,  3);
        check("wrap.empty", empty_o, 1);

        // Illegal request clamps and sets the sticky error
        step(7, 0, 5, 0, "illegal");
        check("illegal.err", err_o, 1);
        check("illegal.occ", occ_o, 5);
        step(0, 0, 0, 0, "idle");
        check("sticky.err", err_o, 1);
        for (int i = 0; i < 5; i++) begin
            tick(5, 0);
        end
        check("pre_rst.occ", occ_o, 30);

        // Mid-operation reset discards state and the pending request
        reset_n_i = 1'b0;
        tick(5, 0);
        reset_n_i = 1'b1;
        enq_req_i = '0;
        check("midrst.occ",  occ_o,  0);
        check("midrst.err",  err_o,  0);
        check("midrst.wptr", wptr_o, 0);
        check("midrst.free", free_o, 64);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
